// File: rtl/bch_pkg.sv
// Shared definitions for the iterative binary BCH Berlekamp-Massey solver.
package bch_pkg;

    localparam int M_DEF = 4;
    localparam int T_DEF = 2;
    localparam logic [M_DEF:0] PRIM_POLY_DEF = 5'b10011;

    typedef logic [M_DEF-1:0] gf_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width able to hold the register length L for any outcome, including failures.
    function automatic int count_width(input int t);
        return $clog2(2 * t + 2);
    endfunction

    localparam int CNT_W = count_width(T_DEF);

endpackage

// File: rtl/bch_bm_iter_if.sv
// Start/ready request and result bus of the BM solver.
// start is sampled only while ready=1; done is a one-cycle pulse and the
// lambda_o/err_cnt/fail results stay valid and stable until the next done.
interface bch_bm_iter_if
    import bch_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int T = T_DEF
);
    logic                          start;
    logic [2*T*M-1:0]              syn_i;
    logic                          ready;
    logic                          done;
    logic [(T+1)*M-1:0]            lambda_o;
    logic [count_width(T)-1:0]     err_cnt;
    logic                          fail;

    modport master (
        output start, syn_i,
        input  ready, done, lambda_o, err_cnt, fail
    );

    modport slave (
        input  start, syn_i,
        output ready, done, lambda_o, err_cnt, fail
    );
endinterface

// File: rtl/bch_gf_mul.sv
// Combinational GF(2^M) multiplier: shift-and-add reduced by PRIM_POLY.
module bch_gf_mul #(
    parameter int         M         = 4,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    logic [M-1:0] acc;
    logic [M-1:0] sh;

    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_POLY[M-1:0] : '0);
        end
        p = acc;
    end
endmodule

// File: rtl/bch_bm_iter.sv
// Inversionless Berlekamp-Massey for binary BCH: one iteration per clock,
// T iterations per decode, scaled error locator plus L and failure flag.
module bch_bm_iter
    import bch_pkg::*;
#(
    parameter int         M         = M_DEF,
    parameter int         T         = T_DEF,
    parameter logic [M:0] PRIM_POLY = PRIM_POLY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    bch_bm_iter_if.slave      bus,
    output state_t            state_dbg
);
    localparam int CW = count_width(T);
    localparam int KW = CW + 1;

    state_t state, state_nxt;
    logic   load, step, finish;

    logic [2*T*M-1:0]       syn_q;
    logic [M-1:0]           lam_q [T+2];
    logic [M-1:0]           b_q   [T+2];
    logic [M-1:0]           gamma_q;
    logic signed [KW-1:0]   k_q;
    logic [CW-1:0]          l_q;
    logic [CW-1:0]          r_q;

    logic                   done_q;
    logic [(T+1)*M-1:0]     lambda_q;
    logic [CW-1:0]          err_q;
    logic                   fail_q;

    logic [M-1:0]           s_op   [T+1];
    logic [M-1:0]           prod_d [T+1];
    logic [M-1:0]           xb     [T+2];
    logic [M-1:0]           prod_g [T+2];
    logic [M-1:0]           prod_x [T+2];
    logic [M-1:0]           delta;
    logic                   upd;
    logic [CW-1:0]          l_upd;
    int                     idx;
    int                     deg;
    logic                   fail_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: if (bus.start) begin
                state_nxt = ST_RUN;
                load      = 1'b1;
            end
            ST_RUN: begin
                step = 1'b1;
                if (r_q == CW'(T - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Syndrome operand for term i of the discrepancy: S(2r+1-i), zero below S1.
    always_comb begin
        idx = 0;
        for (int i = 0; i <= T; i++) begin
            idx = 2 * int'(r_q) + 1 - i;
            if (idx >= 1 && idx <= 2 * T) s_op[i] = syn_q[(idx-1)*M +: M];
            else                          s_op[i] = '0;
        end
    end

    for (genvar i = 0; i <= T; i++) begin : g_delta
        bch_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_mul (
            .a(lam_q[i]), .b(s_op[i]), .p(prod_d[i])
        );
    end

    always_comb begin
        delta = '0;
        for (int i = 0; i <= T; i++) delta = delta ^ prod_d[i];
        xb[0] = '0;
        for (int i = 1; i < T + 2; i++) xb[i] = b_q[i-1];
    end

    for (genvar i = 0; i < T + 2; i++) begin : g_lam
        bch_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_mul_g (
            .a(gamma_q), .b(lam_q[i]), .p(prod_g[i])
        );
        bch_gf_mul #(.M(M), .PRIM_POLY(PRIM_POLY)) u_mul_x (
            .a(delta), .b(xb[i]), .p(prod_x[i])
        );
    end

    // k tracks r-L, so the length change is taken exactly when L <= r.
    assign upd   = (delta != '0) && !k_q[KW-1];
    assign l_upd = CW'({r_q, 1'b0}) + CW'(1) - l_q;

    always_comb begin
        deg = 0;
        for (int i = 0; i < T + 2; i++) begin
            if (lam_q[i] != '0) deg = i;
        end
        fail_c = (int'(l_q) > T) || (lam_q[T+1] != '0) || (deg != int'(l_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syn_q    <= '0;
            gamma_q  <= '0;
            k_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            done_q   <= 1'b0;
            lambda_q <= '0;
            err_q    <= '0;
            fail_q   <= 1'b0;
            for (int i = 0; i < T + 2; i++) begin
                lam_q[i] <= '0;
                b_q[i]   <= '0;
            end
        end else begin
            done_q <= finish;
            if (load) begin
                syn_q   <= bus.syn_i;
                gamma_q <= M'(1);
                k_q     <= '0;
                l_q     <= '0;
                r_q     <= '0;
                for (int i = 0; i < T + 2; i++) begin
                    lam_q[i] <= (i == 0) ? M'(1) : '0;
                    b_q[i]   <= (i == 0) ? M'(1) : '0;
                end
            end
            if (step) begin
                r_q <= r_q + CW'(1);
                for (int i = 0; i < T + 2; i++) lam_q[i] <= prod_g[i] ^ prod_x[i];
                if (upd) begin
                    gamma_q <= delta;
                    k_q     <= -k_q;
                    l_q     <= l_upd;
                    for (int i = 0; i < T + 2; i++) b_q[i] <= (i == 0) ? '0 : lam_q[i-1];
                end else begin
                    k_q <= k_q + KW'(1);
                    for (int i = 0; i < T + 2; i++) b_q[i] <= (i < 2) ? '0 : b_q[i-2];
                end
            end
            if (finish) begin
                for (int i = 0; i <= T; i++) lambda_q[i*M +: M] <= lam_q[i];
                err_q  <= l_q;
                fail_q <= fail_c;
            end
        end
    end

    assign bus.ready    = (state == ST_IDLE);
    assign bus.done     = done_q;
    assign bus.lambda_o = lambda_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail     = fail_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_bch_bm_iter.sv
// Directed bench for bch_bm_iter at M=4, T=2 over GF(16), x^4+x+1.
module tb_bch_bm_iter;
    import bch_pkg::*;

    logic   clk;
    logic   rst;
    state_t state_dbg;

    bch_bm_iter_if #(.M(4), .T(2)) bus ();

    bch_bm_iter #(.M(4), .T(2), .PRIM_POLY(5'b10011)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    // {fail, err_cnt[2:0], lambda[11:0]}
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            logic [15:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("lambda_o", bus.lambda_o, e[11:0]);
                check("err_cnt", bus.err_cnt, e[14:12]);
                check("fail", bus.fail, e[15]);
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge of the done cycle (or bound).
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, cyc, 4);
    endtask

    task automatic decode(input logic [15:0] syn, input logic [15:0] exp);
        exp_q.push_back(exp);
        bus.syn_i = syn;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ready_low_run", bus.ready, 0);
        wait_done("latency");
    endtask

    localparam logic [15:0] SYN_ZERO = 16'h0000;
    localparam logic [15:0] SYN_ONE  = 16'hFAC8; // S=(8,12,10,15)
    localparam logic [15:0] SYN_TWO  = 16'h2953; // S=(3,5,9,2)
    localparam logic [15:0] SYN_BAD  = 16'h0100; // S=(0,0,1,0)
    localparam logic [15:0] EXP_ZERO = {1'b0, 3'd0, 12'h001};
    localparam logic [15:0] EXP_ONE  = {1'b0, 3'd1, 12'h0C8};
    localparam logic [15:0] EXP_TWO  = {1'b0, 3'd2, 12'h653};
    localparam logic [15:0] EXP_BAD  = {1'b1, 3'd3, 12'h001};

    int base;

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.syn_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_lambda", bus.lambda_o, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b1;
        @(negedge clk);

        decode(SYN_ZERO, EXP_ZERO);
        decode(SYN_ONE, EXP_ONE);
        decode(SYN_TWO, EXP_TWO);
        decode(SYN_BAD, EXP_BAD);
        repeat (3) @(negedge clk);
        check("hold_lambda", bus.lambda_o, EXP_BAD[11:0]);
        check("hold_fail", bus.fail, 1);

        // start pulsed again mid-run must be ignored
        base = done_cnt;
        exp_q.push_back(EXP_ONE);
        bus.syn_i = SYN_ONE;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("run_state", state_dbg, ST_RUN);
        @(negedge clk);
        bus.syn_i = SYN_TWO;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("done_after_ignored_start", bus.done, 1);
        repeat (6) @(negedge clk);
        check("single_done", done_cnt - base, 1);

        // back-to-back: start held through done
        exp_q.push_back(EXP_ONE);
        exp_q.push_back(EXP_TWO);
        bus.syn_i = SYN_ONE;
        bus.start = 1'b1;
        @(negedge clk);
        wait_done("b2b_first_latency");
        check("ready_in_done_cycle", bus.ready, 1);
        bus.syn_i = SYN_TWO;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_second_latency");
        @(negedge clk);

        // reset during the second RUN cycle aborts the decode
        base = done_cnt;
        bus.syn_i = SYN_TWO;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", bus.ready, 1);
        check("abort_done", bus.done, 0);
        check("abort_lambda", bus.lambda_o, 0);
        check("abort_err_cnt", bus.err_cnt, 0);
        check("abort_fail", bus.fail, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt - base, 0);

        decode(SYN_ONE, EXP_ONE);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("total_dones", done_cnt, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
